// File: rtl/inert_pkg.sv
// Shared types and command tables for the inertial-sensor SPI command sequencer.
package inert_pkg;

  typedef enum logic [2:0] {
    STARTUP, CFG_ISSUE, CFG_WAIT, WAIT_INT, RD_ISSUE, RD_WAIT, UPDATE
  } state_t;

  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int NUM_CFG  = 3;
  localparam int NUM_RD   = 4;

  // SPI command word: {read flag, 7-bit register address, write data}
  function automatic logic [15:0] mk_cmd(input logic rd, input logic [6:0] addr,
                                         input logic [7:0] data);
    logic [15:0] c;
    c = '0;
    c[RW_BIT]            = rd;
    c[ADDR_MSB:ADDR_LSB] = addr;
    c[7:0]               = data;
    return c;
  endfunction

  // data-ready interrupt enable, gyro 416 Hz, rounding on
  localparam logic [15:0] CFG_CMDS [NUM_CFG] = '{
    mk_cmd(1'b0, 7'h0D, 8'h02),
    mk_cmd(1'b0, 7'h11, 8'h60),
    mk_cmd(1'b0, 7'h14, 8'h40)
  };

  // pitch-rate low/high, yaw-rate low/high
  localparam logic [15:0] RD_CMDS [NUM_RD] = '{
    mk_cmd(1'b1, 7'h22, 8'h00),
    mk_cmd(1'b1, 7'h23, 8'h00),
    mk_cmd(1'b1, 7'h26, 8'h00),
    mk_cmd(1'b1, 7'h27, 8'h00)
  };

endpackage

// File: rtl/inert_seq_sync2.sv
// Two-flop synchronizer for the sensor's asynchronous data-ready line.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/inert_seq.sv
// SPI command sequencer for the inertial sensor: power-up delay, config writes,
// then a four-read burst per data-ready interrupt producing pitch/yaw rates.
module inert_seq
  import inert_pkg::*;
#(
  parameter int STARTUP_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [15:0] rd_data,
  input  logic        INT,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] pitch_rt,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  state_t               state, nxt;
  logic [STARTUP_W-1:0] timer;
  logic [1:0]           idx, idx_nxt;
  logic                 done_q, done_qq, done_edge;
  logic                 int_s;
  logic                 latch_byte;
  logic [7:0]           ptch_l, ptch_h, yaw_l;
  logic                 unused_hi;

  assign unused_hi = ^rd_data[15:8];

  sync2 u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (INT),
    .q   (int_s)
  );

  // a done level carried over from the previous transaction never looks like an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      done_q  <= 1'b0;
      done_qq <= 1'b0;
    end else begin
      done_q  <= done;
      done_qq <= done_q;
    end

  assign done_edge = done_q & ~done_qq;

  always_comb begin
    nxt        = state;
    idx_nxt    = idx;
    latch_byte = 1'b0;
    unique case (state)
      STARTUP:   if (&timer) begin
                   nxt     = CFG_ISSUE;
                   idx_nxt = '0;
                 end
      CFG_ISSUE: nxt = CFG_WAIT;
      CFG_WAIT:  if (done_edge) begin
                   if (idx == 2'd2) nxt = WAIT_INT;
                   else begin
                     idx_nxt = idx + 2'd1;
                     nxt     = CFG_ISSUE;
                   end
                 end
      WAIT_INT:  if (int_s) begin
                   idx_nxt = '0;
                   nxt     = RD_ISSUE;
                 end
      RD_ISSUE:  nxt = RD_WAIT;
      RD_WAIT:   if (done_edge) begin
                   latch_byte = 1'b1;
                   if (idx == 2'd3) nxt = UPDATE;
                   else begin
                     idx_nxt = idx + 2'd1;
                     nxt     = RD_ISSUE;
                   end
                 end
      UPDATE:    nxt = WAIT_INT;
      default:   nxt = STARTUP;
    endcase
  end

  assign wrt = (state == CFG_ISSUE) || (state == RD_ISSUE);
  assign vld = (state == UPDATE);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= STARTUP;
      idx      <= '0;
      timer    <= '0;
      cmd      <= '0;
      pitch_rt <= '0;
      yaw_rt   <= '0;
      ptch_l   <= '0;
      ptch_h   <= '0;
      yaw_l    <= '0;
    end else begin
      state <= nxt;
      idx   <= idx_nxt;
      if (state == STARTUP) timer <= timer + 1'b1;
      // cmd is loaded on entry to ISSUE and held through the matching WAIT
      if (nxt == CFG_ISSUE) cmd <= CFG_CMDS[idx_nxt];
      if (nxt == RD_ISSUE)  cmd <= RD_CMDS[idx_nxt];
      if (latch_byte) begin
        unique case (idx)
          2'd0:    ptch_l <= rd_data[7:0];
          2'd1:    ptch_h <= rd_data[7:0];
          2'd2:    yaw_l  <= rd_data[7:0];
          default: ;
        endcase
      end
      // yaw high byte is taken straight off the bus so the rates are stable during vld
      if (latch_byte && idx == 2'd3) begin
        pitch_rt <= {ptch_h, ptch_l};
        yaw_rt   <= {rd_data[7:0], yaw_l};
      end
    end

endmodule
